// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The control bundles let the top decode hazards with a single select.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF     = 7'b0000_000;
    localparam ctrl_t CTRL_NORMAL  = 7'b1111_000;
    localparam ctrl_t CTRL_FREEZE  = 7'b0000_001;
    localparam ctrl_t CTRL_BRANCH  = 7'b1111_110;
    localparam ctrl_t CTRL_LOADUSE = 7'b0011_010;

    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] ld_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return mem_read && (ld_rt != REG_ZERO) &&
               ((uses_rs && rs == ld_rt) || (uses_rt && rt == ld_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; synchronous clear beats increment.
module sat_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && count_q != MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken
// branches, data-memory freezes, perf counters and a busy watchdog.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic            timeout_err_q, timeout_err_d;
    logic [TO_W-1:0] wait_cnt;
    ctrl_t           ctrl;
    logic            lu;
    logic            br;
    logic            do_freeze;
    logic            do_branch;
    logic            do_lu;

    assign lu = is_load_use(ex_mem_read, ex_rt, id_rs, id_rt,
                            id_uses_rs, id_uses_rt);

    // A branch seen during a freeze is replayed on the resume cycle.
    assign br = branch_taken | (flush_pend_q & (state_q == FREEZE));

    always_comb begin
        ctrl      = CTRL_OFF;
        do_freeze = 1'b0;
        do_branch = 1'b0;
        do_lu     = 1'b0;
        if (rst_n) begin
            priority case (1'b1)
                mem_busy: begin
                    ctrl      = CTRL_FREEZE;
                    do_freeze = 1'b1;
                end
                br: begin
                    ctrl      = CTRL_BRANCH;
                    do_branch = 1'b1;
                end
                lu: begin
                    ctrl  = CTRL_LOADUSE;
                    do_lu = 1'b1;
                end
                default: ctrl = CTRL_NORMAL;
            endcase
        end
    end

    always_comb begin
        state_d      = mem_busy ? FREEZE : RUN;
        flush_pend_d = flush_pend_q;
        if (mem_busy && branch_taken) begin
            flush_pend_d = 1'b1;
        end else if (do_branch) begin
            flush_pend_d = 1'b0;
        end
        timeout_err_d = timeout_err_q |
                        (mem_busy && wait_cnt >= TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            flush_pend_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_pend_q  <= flush_pend_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clear),
        .inc   (do_freeze | do_lu),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clear),
        .inc   (do_branch),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(TO_W), .MAX(TO_MAX)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!mem_busy),
        .inc   (mem_busy),
        .count (wait_cnt)
    );

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign id_ex_write  = ctrl.id_ex_write;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 5;
    localparam int TO_W    = 8;
    localparam int CMAX    = 15;

    localparam logic [6:0] E_OFF = 7'b0000000;
    localparam logic [6:0] E_NRM = 7'b1111000;
    localparam logic [6:0] E_FRZ = 7'b0000001;
    localparam logic [6:0] E_BR  = 7'b1111110;
    localparam logic [6:0] E_LU  = 7'b0011010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, ex_mem_read;
    logic             branch_taken, mem_busy, cnt_clear;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             timeout_err;
    logic [6:0]       ctrl;

    int checks = 0;
    int errors = 0;

    bit m_pend;
    int m_stall, m_flush, m_run;
    bit m_err;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .cnt_clear(cnt_clear),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .timeout_err(timeout_err)
    );

    assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, mem_wb_flush};

    // Model: 0 reset, 1 freeze, 2 branch, 3 load-use, 4 normal
    function automatic int f_action();
        bit lu;
        lu = ex_mem_read && ex_rt != 0 &&
             ((id_uses_rs && id_rs == ex_rt) ||
              (id_uses_rt && id_rt == ex_rt));
        if (!rst_n) return 0;
        if (mem_busy) return 1;
        if (branch_taken || m_pend) return 2;
        if (lu) return 3;
        return 4;
    endfunction

    function automatic logic [6:0] f_ctrl();
        case (f_action())
            1: return E_FRZ;
            2: return E_BR;
            3: return E_LU;
            4: return E_NRM;
            default: return E_OFF;
        endcase
    endfunction

    task automatic mdl_reset();
        m_pend = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
    endtask

    task automatic mdl_update();
        int a;
        a = f_action();
        if (!rst_n) begin
            mdl_reset();
            return;
        end
        if (cnt_clear) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (a == 1 || a == 3) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (a == 2) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end
        if (mem_busy && branch_taken) m_pend = 1;
        else if (a == 2) m_pend = 0;
        m_run = mem_busy ? m_run + 1 : 0;
        if (m_run >= TIMEOUT) m_err = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic set_idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        branch_taken = 0; mem_busy = 0; cnt_clear = 0;
    endtask

    task automatic drive_random();
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        ex_rt = 5'($urandom_range(0, 3));
        id_uses_rs = 1'($urandom);
        id_uses_rt = 1'($urandom);
        ex_mem_read = 1'($urandom);
        branch_taken = ($urandom_range(0, 99) < 15);
        mem_busy = ($urandom_range(0, 9) < (mem_busy ? 8 : 3));
        cnt_clear = ($urandom_range(0, 99) < 3);
    endtask

    task automatic test_reset();
        set_idle();
        #1;
        rst_n = 1'b0;
        mdl_reset();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(negedge clk);
            checks++;
            if (ctrl !== E_OFF) begin
                errors++;
                $display("FAIL reset_ctrl: got %b expected %b", ctrl, E_OFF);
            end
            checks++;
            if ({stall_cnt, flush_cnt, timeout_err} !== '0) begin
                errors++;
                $display("FAIL reset_regs: stall %0d flush %0d err %b, expected 0",
                         stall_cnt, flush_cnt, timeout_err);
            end
            tick();
        end
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== E_NRM) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", ctrl, E_NRM);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== E_LU) begin
            errors++;
            $display("FAIL lu_ctrl: got %b expected %b", ctrl, E_LU);
        end
        checks++;
        if (stall_cnt !== 0) begin
            errors++;
            $display("FAIL lu_cnt_before: got %0d expected 0", stall_cnt);
        end
        tick();
        ex_rt = 0; id_rs = 0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 1) begin
            errors++;
            $display("FAIL lu_cnt_after: got %0d expected 1", stall_cnt);
        end
        checks++;
        if (ctrl !== E_NRM) begin
            errors++;
            $display("FAIL lu_r0: got %b expected %b", ctrl, E_NRM);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 1) begin
            errors++;
            $display("FAIL lu_r0_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_branch_freeze();
        set_idle();
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        for (int c = 0; c < 5; c++) begin
            mem_busy = (c < 4);
            branch_taken = (c == 1);
            @(negedge clk);
            checks++;
            if (ctrl !== ((c < 4) ? E_FRZ : E_BR)) begin
                errors++;
                $display("FAIL brfrz_c%0d: got %b expected %b", c, ctrl,
                         (c < 4) ? E_FRZ : E_BR);
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (flush_cnt !== 1 || stall_cnt !== 4) begin
            errors++;
            $display("FAIL brfrz_cnt: flush %0d stall %0d, expected 1 and 4",
                     flush_cnt, stall_cnt);
        end
        checks++;
        if (ctrl !== E_NRM) begin
            errors++;
            $display("FAIL brfrz_pend_clr: got %b expected %b", ctrl, E_NRM);
        end
        tick();
    endtask

    task automatic test_branch_lu();
        int s0, f0;
        set_idle();
        s0 = m_stall;
        f0 = m_flush;
        branch_taken = 1;
        ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== E_BR || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL br_lu_ctrl: got %b expected %b", ctrl, E_BR);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== CNT_W'(s0) || flush_cnt !== CNT_W'(f0 + 1)) begin
            errors++;
            $display("FAIL br_lu_cnt: stall %0d flush %0d, expected %0d and %0d",
                     stall_cnt, flush_cnt, s0, f0 + 1);
        end
    endtask

    task automatic test_saturation();
        int r;
        set_idle();
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(1, 31);
            ex_mem_read = 1;
            ex_rt = 5'(r);
            id_uses_rs = i[0];
            id_uses_rt = !i[0];
            id_rs = 5'(r);
            id_rt = 5'(r);
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_stall: got %0d expected 15", stall_cnt);
        end
        cnt_clear = 1;
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++;
            $display("FAIL sat_clear: stall %0d flush %0d, expected 0",
                     stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_watchdog();
        set_idle();
        for (int k = 0; k < 5; k++) begin
            mem_busy = (k < 4);
            tick();
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_short: got %b expected 0", timeout_err);
        end
        for (int k = 1; k <= 7; k++) begin
            mem_busy = 1;
            tick();
            @(negedge clk);
            checks++;
            if (timeout_err !== (k >= TIMEOUT)) begin
                errors++;
                $display("FAIL wd_busy%0d: got %b expected %b", k,
                         timeout_err, k >= TIMEOUT);
            end
        end
        mem_busy = 0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky: got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_freeze();
        set_idle();
        mem_busy = 1;
        branch_taken = 1;
        tick();
        branch_taken = 0;
        tick();
        rst_n = 1'b0;
        mdl_reset();
        branch_taken = 1'($urandom);
        @(negedge clk);
        checks++;
        if (ctrl !== E_OFF || {stall_cnt, flush_cnt, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rstfrz_low: ctrl %b stall %0d flush %0d err %b, expected 0",
                     ctrl, stall_cnt, flush_cnt, timeout_err);
        end
        tick();
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== E_NRM) begin
            errors++;
            $display("FAIL rstfrz_release: got %b expected %b", ctrl, E_NRM);
        end
        tick();
        @(negedge clk);
        checks++;
        if (flush_cnt !== 0) begin
            errors++;
            $display("FAIL rstfrz_flush_cnt: got %0d expected 0", flush_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        set_idle();
        for (int i = 0; i < 600; i++) begin
            drive_random();
            rst_n = ($urandom_range(0, 149) != 0);
            if (!rst_n) mdl_reset();
            @(negedge clk);
            e = f_ctrl();
            checks++;
            if ({ctrl, stall_cnt, flush_cnt, timeout_err} !==
                {e, CNT_W'(m_stall), CNT_W'(m_flush), m_err}) begin
                errors++;
                $display("FAIL rand_%0d: ctrl %b stall %0d flush %0d err %b, expected %b %0d %0d %b",
                         i, ctrl, stall_cnt, flush_cnt, timeout_err,
                         e, m_stall, m_flush, m_err);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        mdl_reset();
        test_reset();
        test_load_use();
        test_branch_freeze();
        test_branch_lu();
        test_saturation();
        test_watchdog();
        test_reset_mid_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
